// File: rtl/host_cfg_receiver_pkg.sv
// Shared definitions for the host configuration receiver: sync marker and
// state encodings for the RX core and the frame parser.
package host_cfg_receiver_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hFF;

  typedef enum logic [3:0] {
    PS_WAIT_SYNC = 4'b0001,
    PS_GET_INDEX = 4'b0010,
    PS_GET_TAPS  = 4'b0100,
    PS_GET_CHK   = 4'b1000
  } parser_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/host_cfg_receiver_uart_rx.sv
// 8N1 UART receiver: synchronises RX, times bits with a down-counter and
// reports each byte as a byte_valid pulse or a frame_err pulse.
//
// state    | meaning
// ---------+---------------------------------------------------------
// RX_IDLE  | line idle, waiting for a falling edge
// RX_START | half a bit in, confirming the start bit (glitch filter)
// RX_DATA  | sampling 8 data bits mid-bit, LSB first
// RX_STOP  | sampling the stop bit, then reporting the byte or an error
module uart_rx_core
  import host_cfg_receiver_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err,
  output logic       rx_idle
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] FULL_BIT = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_BIT = TW'(CLKS_PER_BIT / 2 - 1);

  rx_state_t     state;
  logic [TW-1:0] timer;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          rx_meta;
  logic          rx_sync;
  logic          rx_last;

  assign rx_idle = (state == RX_IDLE);

  // Two-flop synchroniser plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_last <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_last <= rx_sync;
    end
  end

  // Bit timing and byte assembly; outputs are registered one-cycle pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RX_IDLE;
      timer      <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (rx_last && !rx_sync) begin
            state <= RX_START;
            timer <= HALF_BIT;
          end
        end
        RX_START: begin
          if (timer != '0) begin
            timer <= timer - 1'b1;
          end else if (!rx_sync) begin
            state   <= RX_DATA;
            timer   <= FULL_BIT;
            bit_idx <= '0;
          end else begin
            state <= RX_IDLE;
          end
        end
        RX_DATA: begin
          if (timer != '0) begin
            timer <= timer - 1'b1;
          end else begin
            shreg   <= {rx_sync, shreg[7:1]};
            timer   <= FULL_BIT;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (timer != '0) begin
            timer <= timer - 1'b1;
          end else begin
            if (rx_sync) begin
              byte_valid <= 1'b1;
              rx_byte    <= shreg;
            end else begin
              frame_err <= 1'b1;
            end
            state <= RX_IDLE;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/host_cfg_receiver.sv
// Host configuration receiver: parses FF / index / taps / XOR-checksum
// frames from the UART and strobes the tap vector into the addressed module.
//
// state        | meaning
// -------------+------------------------------------------------------
// PS_WAIT_SYNC | idle, looking for the 0xFF sync byte
// PS_GET_INDEX | expecting the module index (0xFF here resyncs)
// PS_GET_TAPS  | collecting tap bytes, first byte lands in the LSB byte
// PS_GET_CHK   | comparing the XOR checksum, then load or error
module host_cfg_receiver
  import host_cfg_receiver_pkg::*;
#(
  parameter int NUM_OF_TAPS    = 5,
  parameter int NUM_OF_MODULES = 20,
  parameter int CLKS_PER_BIT   = 434,
  parameter int TIMEOUT_BITS   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      RX,
  output logic [NUM_OF_TAPS*8-1:0]  cfg_taps,
  output logic [5:0]                cfg_index,
  output logic [NUM_OF_MODULES-1:0] cfg_load,
  output logic                      cfg_valid,
  output logic                      cfg_err,
  output logic                      busy
);

  localparam int KW        = $clog2(NUM_OF_TAPS + 1);
  localparam int TO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TOW       = $clog2(TO_CYCLES);
  // Reload chosen so cfg_err lands exactly TO_CYCLES clocks after byte_valid:
  // one clock for the reload, one for the registered error output.
  localparam logic [TOW-1:0]            TO_RELOAD = TOW'(TO_CYCLES - 2);
  localparam logic [KW-1:0]             LAST_TAP  = KW'(NUM_OF_TAPS - 1);
  localparam logic [7:0]                MOD_LIMIT = 8'(NUM_OF_MODULES);
  localparam logic [NUM_OF_MODULES-1:0] LOAD_ONE  = NUM_OF_MODULES'(1);

  logic [7:0]               rx_byte;
  logic                     byte_valid;
  logic                     frame_err;
  logic                     rx_idle;
  parser_state_t            state;
  logic [5:0]               index_q;
  logic [KW-1:0]            tap_k;
  logic [7:0]               chk;
  logic [NUM_OF_TAPS*8-1:0] shadow;
  logic [TOW-1:0]           to_cnt;
  logic                     timeout;

  uart_rx_core #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rx         (RX),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .frame_err  (frame_err),
    .rx_idle    (rx_idle)
  );

  assign busy    = (state != PS_WAIT_SYNC);
  assign timeout = busy && rx_idle && (to_cnt == '0);

  // Inter-byte silence timer: reloaded by every good byte, parks at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (byte_valid) begin
      to_cnt <= TO_RELOAD;
    end else if (to_cnt != '0) begin
      to_cnt <= to_cnt - 1'b1;
    end
  end

  // Frame parser; accepted frames update the held outputs one clock later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= PS_WAIT_SYNC;
      index_q   <= '0;
      tap_k     <= '0;
      chk       <= '0;
      shadow    <= '0;
      cfg_taps  <= '0;
      cfg_index <= '0;
      cfg_load  <= '0;
      cfg_valid <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      cfg_valid <= 1'b0;
      cfg_err   <= 1'b0;
      cfg_load  <= '0;
      if (frame_err && state != PS_WAIT_SYNC) begin
        cfg_err <= 1'b1;
        state   <= PS_WAIT_SYNC;
      end else if (byte_valid) begin
        case (state)
          PS_WAIT_SYNC: begin
            if (rx_byte == SYNC_BYTE) state <= PS_GET_INDEX;
          end
          PS_GET_INDEX: begin
            if (rx_byte == SYNC_BYTE) begin
              state <= PS_GET_INDEX;
            end else if (rx_byte >= MOD_LIMIT) begin
              cfg_err <= 1'b1;
              state   <= PS_WAIT_SYNC;
            end else begin
              index_q <= rx_byte[5:0];
              chk     <= rx_byte;
              tap_k   <= '0;
              state   <= PS_GET_TAPS;
            end
          end
          PS_GET_TAPS: begin
            shadow[tap_k*8 +: 8] <= rx_byte;
            chk                  <= chk ^ rx_byte;
            tap_k                <= tap_k + 1'b1;
            if (tap_k == LAST_TAP) state <= PS_GET_CHK;
          end
          PS_GET_CHK: begin
            if (rx_byte == chk) begin
              cfg_valid <= 1'b1;
              cfg_taps  <= shadow;
              cfg_index <= index_q;
              cfg_load  <= LOAD_ONE << index_q;
            end else begin
              cfg_err <= 1'b1;
            end
            state <= PS_WAIT_SYNC;
          end
          default: state <= PS_WAIT_SYNC;
        endcase
      end else if (timeout) begin
        cfg_err <= 1'b1;
        state   <= PS_WAIT_SYNC;
      end
    end
  end

endmodule

// File: tb/tb_host_cfg_receiver.sv
// Scoreboard bench for host_cfg_receiver with a short bit time.
module tb_host_cfg_receiver;

  localparam int CPB    = 16;
  localparam int TAPS   = 5;
  localparam int MODS   = 20;
  localparam int TO_BIT = 16;
  localparam int TO_CYC = TO_BIT * CPB;

  typedef struct {
    bit          is_err;
    bit          timed;
    logic [5:0]  idx;
    logic [39:0] taps;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            RX  = 1'b1;
  logic [39:0]     cfg_taps;
  logic [5:0]      cfg_index;
  logic [MODS-1:0] cfg_load;
  logic            cfg_valid;
  logic            cfg_err;
  logic            busy;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_evt = 0;
  int          cyc = 0;
  int          last_bv = 0;
  logic [39:0] mdl_taps = '0;
  logic [5:0]  mdl_idx = '0;

  host_cfg_receiver #(
    .NUM_OF_TAPS    (TAPS),
    .NUM_OF_MODULES (MODS),
    .CLKS_PER_BIT   (CPB),
    .TIMEOUT_BITS   (TO_BIT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .RX        (RX),
    .cfg_taps  (cfg_taps),
    .cfg_index (cfg_index),
    .cfg_load  (cfg_load),
    .cfg_valid (cfg_valid),
    .cfg_err   (cfg_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every valid/err pulse must match the head of the queue.
  always @(negedge clk) begin
    exp_t e;
    if (dut.byte_valid) last_bv = cyc;
    if (!rst && (cfg_valid || cfg_err)) begin
      n_evt++;
      if (exp_q.size() == 0) begin
        check_val("unexpected_evt", 64'({cfg_valid, cfg_err}), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check_val("valid_err_excl", 64'(cfg_valid & cfg_err), 64'd0);
        if (e.is_err) begin
          check_val("err_pulse", 64'(cfg_err), 64'd1);
          check_val("err_keep_taps", 64'(cfg_taps), 64'(mdl_taps));
          check_val("err_keep_idx", 64'(cfg_index), 64'(mdl_idx));
          check_val("err_load", 64'(cfg_load), 64'd0);
          if (e.timed) check_val("timeout_lat", 64'(cyc - last_bv), 64'(TO_CYC));
        end else begin
          check_val("valid_pulse", 64'(cfg_valid), 64'd1);
          check_val("valid_lat", 64'(cyc - last_bv), 64'd1);
          check_val("load", 64'(cfg_load), 64'(MODS'(1) << e.idx));
          check_val("index", 64'(cfg_index), 64'(e.idx));
          check_val("taps", 64'(cfg_taps), 64'(e.taps));
          mdl_taps = e.taps;
          mdl_idx  = e.idx;
        end
      end
    end
  end

  task automatic bit_time(input logic v);
    RX = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
    bit_time(bad_stop ? 1'b0 : 1'b1);
    RX = 1'b1;
  endtask

  task automatic send_frame(input logic [5:0] idx, input logic [39:0] taps,
                            input bit bad_chk);
    logic [7:0] c;
    c = {2'b00, idx};
    send_byte(8'hFF, 1'b0);
    send_byte({2'b00, idx}, 1'b0);
    for (int k = 0; k < TAPS; k++) begin
      send_byte(taps[k*8 +: 8], 1'b0);
      c = c ^ taps[k*8 +: 8];
    end
    send_byte(bad_chk ? 8'h00 : c, 1'b0);
  endtask

  task automatic push_exp(input bit is_err, input bit timed, input logic [5:0] idx,
                          input logic [39:0] taps);
    exp_t e;
    e.is_err = is_err;
    e.timed  = timed;
    e.idx    = idx;
    e.taps   = taps;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40 * CPB) begin
      @(negedge clk);
      n++;
    end
    check_val(tag, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_taps"}, 64'(cfg_taps), 64'd0);
    check_val({tag, "_index"}, 64'(cfg_index), 64'd0);
    check_val({tag, "_load"}, 64'(cfg_load), 64'd0);
    check_val({tag, "_valid"}, 64'(cfg_valid), 64'd0);
    check_val({tag, "_err"}, 64'(cfg_err), 64'd0);
    check_val({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int evt0;
    repeat (4) @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b0;
    repeat (2 * CPB) @(negedge clk);

    // Basic frame for module 3
    push_exp(1'b0, 1'b0, 6'd3, 40'h5544332211);
    send_frame(6'd3, 40'h5544332211, 1'b0);
    wait_drain("drain_basic");

    // Same frame with a wrong checksum
    push_exp(1'b1, 1'b0, 6'd0, 40'h0);
    send_frame(6'd3, 40'h5544332211, 1'b1);
    wait_drain("drain_badchk");

    // Out-of-range index, then a good frame for module 0
    push_exp(1'b1, 1'b0, 6'd0, 40'h0);
    send_byte(8'hFF, 1'b0);
    send_byte(8'h14, 1'b0);
    wait_drain("drain_badidx");
    check_val("badidx_busy", 64'(busy), 64'd0);
    push_exp(1'b0, 1'b0, 6'd0, 40'h0504030201);
    send_frame(6'd0, 40'h0504030201, 1'b0);
    wait_drain("drain_idx0");

    // Repeated sync bytes and an FF tap byte
    push_exp(1'b0, 1'b0, 6'd2, 40'h7E5A00FFA5);
    send_byte(8'hFF, 1'b0);
    send_byte(8'hFF, 1'b0);
    send_frame(6'd2, 40'h7E5A00FFA5, 1'b0);
    wait_drain("drain_resync");

    // Stop bit low on the third byte
    push_exp(1'b1, 1'b0, 6'd0, 40'h0);
    send_byte(8'hFF, 1'b0);
    send_byte(8'h05, 1'b0);
    send_byte(8'h10, 1'b1);
    wait_drain("drain_stopbit");
    check_val("stopbit_busy", 64'(busy), 64'd0);

    // Quarter-bit glitch on an idle line
    evt0 = n_evt;
    RX = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    RX = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check_val("glitch_evt", 64'(n_evt), 64'(evt0));
    check_val("glitch_busy", 64'(busy), 64'd0);

    // Silence after the second tap byte
    push_exp(1'b1, 1'b1, 6'd0, 40'h0);
    send_byte(8'hFF, 1'b0);
    send_byte(8'h07, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    repeat (20 * CPB) @(negedge clk);
    wait_drain("drain_timeout");
    check_val("timeout_busy", 64'(busy), 64'd0);

    // Reset in the middle of a tap byte
    send_byte(8'hFF, 1'b0);
    send_byte(8'h08, 1'b0);
    send_byte(8'h11, 1'b0);
    bit_time(1'b0);
    bit_time(1'b1);
    bit_time(1'b0);
    rst = 1'b1;
    RX  = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("midrst");
    mdl_taps = '0;
    mdl_idx  = '0;
    rst = 1'b0;
    repeat (2 * CPB) @(negedge clk);
    check_val("midrst_evt_q", 64'(exp_q.size()), 64'd0);
    push_exp(1'b0, 1'b0, 6'd19, 40'hC0FFEE1234);
    send_frame(6'd19, 40'hC0FFEE1234, 1'b0);
    wait_drain("drain_after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #(600_000 * 10);
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
